spi_slave_byte: RTL and testbench

Byte-oriented SPI responder: the far end of our SPI master path, used where the FPGA itself is addressed by an external SPI master. It oversamples the SPI pins in `sys_clk`, shifts MOSI bytes out as `rx_data`/`rx_valid` strobes, and serves MISO bytes from a show-ahead FIFO. The read port matches the FIFO-facing port of the master-side byte engine. Frame length is checked against `BYTES_PER_FRAME` when chip select is released.

---
 rtl/spi_slave_pkg.sv | 28 ++
 rtl/spi_slave_byte_sync.sv | 40 ++++
 rtl/spi_slave_byte.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_slave_byte.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI byte responder.
//   state_e          - responder FSM states
//   BIT_CNT_W        - width of the in-byte bit counter
//   BYTE_CNT_MAX     - saturation value of the per-frame byte counter
//   SETTLE_CYCLES    - cycles after reset before the synchronized chip select is trusted
//   frame_malformed  - frame-length check applied when chip select is released
package spi_slave_pkg;

    typedef enum logic [1:0] {
        StWaitIdle,
        StIdle,
        StActive
    } state_e;

    localparam int unsigned BIT_CNT_W     = 3;
    localparam int unsigned BYTE_CNT_MAX  = 255;
    localparam int unsigned SETTLE_CYCLES = 3;

    // A frame is good only if it ended on a byte boundary with the expected byte count.
    function automatic logic frame_malformed(
        input logic [BIT_CNT_W-1:0] bit_cnt,
        input logic [7:0]           byte_cnt,
        input int unsigned          expected
    );
        return (bit_cnt != '0) || (32'(byte_cnt) != expected);
    endfunction

endpackage

// File: rtl/spi_slave_byte_sync.sv
// sync_edge: two-flop synchronizer for an asynchronous pin plus a one-flop edge register.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   din   in   asynchronous pin
//   sync  out  synchronized level
//   rise  out  1-cycle strobe: synchronized level went 0 -> 1
//   fall  out  1-cycle strobe: synchronized level went 1 -> 0
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_byte.sv
// spi_slave_byte: byte-oriented SPI responder, oversampling the SPI pins in sys_clk.
// MOSI bytes are reported as rx_data/rx_valid strobes; MISO bytes come from a show-ahead
// TX FIFO (FILL_BYTE when empty). Frame length is checked when n_cs is released.
// Ports:
//   sys_clk     in   system clock, at least 8x sclk
//   rst         in   synchronous active-high reset
//   n_cs        in   chip select, active low, asynchronous
//   sclk        in   SPI clock, asynchronous
//   mosi        in   SPI data in, asynchronous
//   miso        out  SPI data out, registered
//   miso_oe     out  MISO pad enable, high while selected
//   tx_data     in   head of the show-ahead TX FIFO
//   tx_empty    in   TX FIFO empty
//   tx_rdreq    out  1-cycle TX FIFO pop strobe
//   rx_data     out  last received byte, held until the next one
//   rx_valid    out  1-cycle strobe, rx_data is new
//   frame_done  out  1-cycle strobe on n_cs release
//   frame_err   out  with frame_done: frame was malformed
module spi_slave_byte
    import spi_slave_pkg::*;
#(
    parameter bit          CPOL            = 1'b0,
    parameter bit          CPHA            = 1'b0,
    parameter int unsigned BYTES_PER_FRAME = 2,
    parameter logic [7:0]  FILL_BYTE       = 8'hFF
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       n_cs,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_rdreq,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_done,
    output logic       frame_err
);

    // ---------------------------------------------------------------- pin synchronisation
    logic sclk_sync;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_sync;
    logic cs_rise;
    logic cs_fall;
    logic mosi_meta_q;
    logic mosi_sync_q;

    sync_edge #(
        .RESET_VAL (CPOL)
    ) u_sclk_sync (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (sclk),
        .sync (sclk_sync),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (n_cs),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // ---------------------------------------------------------------- edge classification
    logic sclk_edge;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic drive_edge;

    // An edge is leading when the new level is the active (non-idle) level.
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge & (sclk_sync ^ CPOL);
    assign trail_edge  = sclk_edge & ~(sclk_sync ^ CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;

    // ---------------------------------------------------------------- state
    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           byte_cnt_q, byte_cnt_d;
    logic [6:0]           shift_in_q, shift_in_d;
    logic [7:0]           shift_out_q, shift_out_d;
    logic                 miso_q, miso_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_rdreq_q, tx_rdreq_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;
    logic [1:0]           settle_q, settle_d;
    logic                 settle_done;
    logic                 load_tx;

    // After reset the chip-select synchronizer still holds its reset value (high) for a
    // couple of cycles; waiting for it to flush keeps a frame in progress at reset from
    // looking like a fresh idle period followed by a select.
    assign settle_done = (settle_q == 2'(SETTLE_CYCLES));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_rdreq_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        load_tx      = 1'b0;
        settle_d     = settle_done ? settle_q : settle_q + 2'd1;
        // MISO trails shift_out by one cycle so a freshly loaded byte shows bit 7 next cycle.
        miso_d       = (state_q == StActive) ? shift_out_q[7] : 1'b0;

        unique case (state_q)
            StWaitIdle: begin
                if (settle_done && cs_sync) begin
                    state_d = StIdle;
                end
            end

            StIdle: begin
                if (cs_fall) begin
                    state_d    = StActive;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    load_tx    = !CPHA;
                end
            end

            StActive: begin
                // Deselect wins over any sclk edge seen in the same cycle.
                if (cs_rise) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                    frame_err_d  = frame_malformed(bit_cnt_q, byte_cnt_q, BYTES_PER_FRAME);
                end else if (sample_edge) begin
                    shift_in_d = {shift_in_q[5:0], mosi_sync_q};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == '1) begin
                        rx_data_d  = {shift_in_q, mosi_sync_q};
                        rx_valid_d = 1'b1;
                        if (byte_cnt_q != 8'(BYTE_CNT_MAX)) begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end else if (drive_edge) begin
                    if (bit_cnt_q == '0) begin
                        load_tx = 1'b1;
                    end else begin
                        shift_out_d = {shift_out_q[6:0], 1'b0};
                    end
                end
            end

            default: state_d = StWaitIdle;
        endcase

        if (load_tx) begin
            if (!tx_empty) begin
                shift_out_d = tx_data;
                tx_rdreq_d  = 1'b1;
            end else begin
                shift_out_d = FILL_BYTE;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= StWaitIdle;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            shift_in_q   <= '0;
            shift_out_q  <= '0;
            miso_q       <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            tx_rdreq_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_in_q   <= shift_in_d;
            shift_out_q  <= shift_out_d;
            miso_q       <= miso_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_rdreq_q   <= tx_rdreq_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            settle_q     <= settle_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = (state_q == StActive);
    assign tx_rdreq   = tx_rdreq_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: one instance per SPI mode sharing the pins through a mode select,
// a bit-level SPI master, a TX FIFO model and a queue-based scoreboard.
module tb_spi_slave_byte;

    localparam int         HALF = 4;  // sclk half period in sys_clk cycles (sclk = sys_clk/8)
    localparam logic [7:0] FILL = 8'hFF;

    logic       sys_clk;
    logic       rst;
    logic       n_cs_pin;
    logic       sclk_pin;
    logic       mosi_pin;
    logic [1:0] mode;

    logic [3:0] sclk_a, n_cs_a;
    logic [3:0] miso_a, miso_oe_a, tx_rdreq_a, rx_valid_a, frame_done_a, frame_err_a;
    logic [7:0] rx_data_a [4];

    logic       tx_empty;
    logic [7:0] tx_data;

    // TX FIFO model: tx_mem holds tx_n entries loaded at tx_base; rd_total counts pops.
    logic [7:0] tx_mem [8];
    int         tx_n;
    int         tx_base;
    int         rd_total = 0;
    int         tx_idx;

    logic [7:0] mo_mem [4];

    logic [7:0] exp_rx [$];
    logic       exp_fd [$];

    int errors = 0;
    int checks = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam bit GCPOL = (g >= 2);
        localparam bit GCPHA = ((g % 2) == 1);

        assign sclk_a[g] = (mode == 2'(g)) ? sclk_pin : GCPOL;
        assign n_cs_a[g] = (mode == 2'(g)) ? n_cs_pin : 1'b1;

        spi_slave_byte #(
            .CPOL            (GCPOL),
            .CPHA            (GCPHA),
            .BYTES_PER_FRAME (2),
            .FILL_BYTE       (FILL)
        ) u_dut (
            .sys_clk    (sys_clk),
            .rst        (rst),
            .n_cs       (n_cs_a[g]),
            .sclk       (sclk_a[g]),
            .mosi       (mosi_pin),
            .miso       (miso_a[g]),
            .miso_oe    (miso_oe_a[g]),
            .tx_data    (tx_data),
            .tx_empty   (tx_empty),
            .tx_rdreq   (tx_rdreq_a[g]),
            .rx_data    (rx_data_a[g]),
            .rx_valid   (rx_valid_a[g]),
            .frame_done (frame_done_a[g]),
            .frame_err  (frame_err_a[g])
        );
    end

    logic       miso_m, miso_oe_m, tx_rdreq_m, rx_valid_m, frame_done_m, frame_err_m;
    logic [7:0] rx_data_m;

    assign miso_m       = miso_a[mode];
    assign miso_oe_m    = miso_oe_a[mode];
    assign tx_rdreq_m   = tx_rdreq_a[mode];
    assign rx_valid_m   = rx_valid_a[mode];
    assign frame_done_m = frame_done_a[mode];
    assign frame_err_m  = frame_err_a[mode];
    assign rx_data_m    = rx_data_a[mode];

    always_comb begin
        tx_idx   = rd_total - tx_base;
        tx_empty = (tx_idx >= tx_n);
        tx_data  = tx_empty ? 8'h00 : tx_mem[tx_idx[2:0]];
    end

    always @(posedge sys_clk) begin
        if (tx_rdreq_m) rd_total <= rd_total + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding expectation.
    logic [7:0] mon_rx;
    logic       mon_fd;
    always @(negedge sys_clk) begin
        if (rx_valid_m) begin
            if (exp_rx.size() == 0) begin
                check("rx_valid_unexpected", 1, 0);
            end else begin
                mon_rx = exp_rx.pop_front();
                check("rx_data", rx_data_m, mon_rx);
            end
        end
        if (frame_done_m) begin
            if (exp_fd.size() == 0) begin
                check("frame_done_unexpected", 1, 0);
            end else begin
                mon_fd = exp_fd.pop_front();
                check("frame_err", frame_err_m, mon_fd);
            end
        end
    end

    // Byte k of a frame's MISO stream: FIFO contents in order, then the fill byte.
    function automatic logic [7:0] exp_miso_byte(input int k);
        return (k < tx_n) ? tx_mem[k] : FILL;
    endfunction

    task automatic load_tx(input int n);
        tx_base = rd_total;
        tx_n    = n;
        for (int i = 0; i < 8; i++) tx_mem[i] = 8'($urandom);
    endtask

    task automatic rand_mo();
        for (int i = 0; i < 4; i++) mo_mem[i] = 8'($urandom);
    endtask

    // One SPI frame of nbits bits in mode m; rst is pulsed just before bit rst_bit (-1: never).
    task automatic run_frame(input logic [1:0] m, input int nbits, input int rst_bit);
        bit         cpol, cpha, aborted, err;
        int         loads, pops;
        logic [7:0] mb, eb;
        cpol    = m[1];
        cpha    = m[0];
        aborted = 1'b0;
        sclk_pin = cpol;
        @(negedge sys_clk);
        mode = m;
        repeat (4) @(negedge sys_clk);

        n_cs_pin = 1'b0;
        repeat (2 * HALF) @(negedge sys_clk);
        check("miso_oe_selected", miso_oe_m, 1);
        if (nbits == 0 && !cpha) begin
            eb = exp_miso_byte(0);
            check("miso_first_bit_no_sclk", miso_m, eb[7]);
        end

        for (int b = 0; b < nbits; b++) begin
            if (b == rst_bit) begin
                rst = 1'b1;
                @(negedge sys_clk);
                rst = 1'b0;
                aborted = 1'b1;
            end
            mb = mo_mem[b / 8];
            eb = exp_miso_byte(b / 8);
            if (!cpha) begin
                mosi_pin = mb[7 - b % 8];
                repeat (HALF) @(negedge sys_clk);
                if (!aborted) check("miso_bit", miso_m, eb[7 - b % 8]);
                sclk_pin = ~cpol;
                if (b % 8 == 7 && !aborted) exp_rx.push_back(mb);
                repeat (HALF) @(negedge sys_clk);
                sclk_pin = cpol;
            end else begin
                sclk_pin = ~cpol;
                mosi_pin = mb[7 - b % 8];
                repeat (HALF) @(negedge sys_clk);
                if (!aborted) check("miso_bit", miso_m, eb[7 - b % 8]);
                sclk_pin = cpol;
                if (b % 8 == 7 && !aborted) exp_rx.push_back(mb);
                repeat (HALF) @(negedge sys_clk);
            end
        end
        repeat (HALF) @(negedge sys_clk);

        n_cs_pin = 1'b1;
        err = (nbits % 8 != 0) || (nbits / 8 != 2);
        if (!aborted) exp_fd.push_back(err);
        repeat (16) @(negedge sys_clk);

        check("miso_oe_released", miso_oe_m, 0);
        check("rx_expectations_drained", exp_rx.size(), 0);
        check("frame_done_expectations_drained", exp_fd.size(), 0);
        if (!aborted) begin
            // CPHA=0 loads at select and after every whole byte; CPHA=1 at each byte start.
            loads = cpha ? (nbits + 7) / 8 : 1 + nbits / 8;
            pops  = (loads < tx_n) ? loads : tx_n;
            check("tx_rdreq_count", rd_total - tx_base, pops);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        n_cs_pin = 1'b1;
        sclk_pin = 1'b0;
        mosi_pin = 1'b0;
        mode     = 2'd0;
        tx_n     = 0;
        tx_base  = 0;
        for (int i = 0; i < 8; i++) tx_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) mo_mem[i] = 8'h00;
        repeat (4) @(negedge sys_clk);

        check("reset_miso", miso_a, 0);
        check("reset_miso_oe", miso_oe_a, 0);
        check("reset_tx_rdreq", tx_rdreq_a, 0);
        check("reset_rx_valid", rx_valid_a, 0);
        check("reset_frame_done", frame_done_a, 0);
        check("reset_frame_err", frame_err_a, 0);
        for (int i = 0; i < 4; i++) check("reset_rx_data", rx_data_a[i], 0);

        rst = 1'b0;
        repeat (10) @(negedge sys_clk);

        // Same two-byte traffic in all four modes.
        for (int m = 0; m < 4; m++) begin
            load_tx(2);
            tx_mem[0] = 8'hA5;
            tx_mem[1] = 8'h3C;
            mo_mem[0] = 8'h12;
            mo_mem[1] = 8'h34;
            run_frame(2'(m), 16, -1);
        end

        // Empty TX FIFO: fill bytes, no pops.
        load_tx(0); rand_mo(); run_frame(2'd0, 16, -1);
        load_tx(0); rand_mo(); run_frame(2'd3, 16, -1);

        // Malformed frames: short with a partial byte, and one byte too many.
        load_tx(2); rand_mo(); run_frame(2'd0, 11, -1);
        load_tx(3); rand_mo(); run_frame(2'd1, 24, -1);
        load_tx(3); rand_mo(); run_frame(2'd2, 24, -1);

        // Reset mid-byte with chip select held low, then a clean frame.
        load_tx(2); rand_mo(); run_frame(2'd0, 16, 4);
        load_tx(2); rand_mo(); run_frame(2'd0, 16, -1);
        load_tx(2); rand_mo(); run_frame(2'd1, 16, 12);
        load_tx(2); rand_mo(); run_frame(2'd1, 16, -1);

        // Select with no sclk activity.
        load_tx(1);
        tx_mem[0] = 8'hA5;
        run_frame(2'd0, 0, -1);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            logic [1:0] rm;
            int         nb;
            rm = 2'($urandom_range(0, 3));
            nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : 16;
            load_tx(int'($urandom_range(0, 3)));
            rand_mo();
            run_frame(rm, nb, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
